spi_flash_xfer: RTL and testbench

Byte-level SPI master (mode 0, MSB first) between the USB-to-SPI bridge endpoint and the SPI flash pins of the bootloader. The bridge frames a flash command by holding `cs_req` high and streams command, address and data bytes through a valid/ready byte interface. Every byte sent returns one byte read from MISO. The block owns chip-select timing and SCK generation, so the endpoint never handles pin-level timing.

---
 rtl/spi_flash_xfer.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_xfer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_xfer.sv
// spi_flash_xfer: byte-level SPI mode-0 master (MSB first) that frames
// flash commands for the USB-to-SPI bridge and owns CS/SCK timing.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   cs_req              high keeps the flash transaction (CS) open
//   tx_valid/tx_ready   byte-in handshake, tx_data is the byte to send
//   rx_valid/rx_ready   byte-out handshake, rx_data is the byte received
//   busy                high whenever the engine is not idle
//   spi_cs_b, spi_sck   flash chip select (active low) and serial clock
//   spi_mosi, spi_miso  serial data out / in
//
// CLK_DIV is the SCK half-period in clk cycles (>= 1).

module spi_flash_xfer #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_req,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       busy,
    output logic       spi_cs_b,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    // Phase counter is wide enough for the 2*CLK_DIV release hold.
    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [PW-1:0] HALF_END = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] REL_END  = PW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        SHIFT,
        RX_WAIT,
        RELEASE
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_next;
    // Bit 7 of the outgoing byte goes straight to MOSI on accept,
    // so only the remaining seven bits are kept here.
    logic [6:0]    tx_sh;
    logic [6:0]    tx_sh_next;
    logic [7:0]    rx_sh;
    logic [7:0]    rx_sh_next;

    logic       cs_b_next;
    logic       sck_next;
    logic       mosi_next;
    logic       tx_ready_next;
    logic       rx_valid_next;
    logic [7:0] rx_data_next;
    logic       busy_next;
    logic       accept;

    // A byte offered in the same cycle cs_req drops is refused even
    // though tx_ready (registered) may still read high.
    assign accept = (state == ACTIVE) && tx_ready && tx_valid && cs_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        phase_next    = phase;
        bit_cnt_next  = bit_cnt;
        tx_sh_next    = tx_sh;
        rx_sh_next    = rx_sh;
        cs_b_next     = spi_cs_b;
        sck_next      = spi_sck;
        mosi_next     = spi_mosi;
        tx_ready_next = 1'b0;
        rx_valid_next = rx_valid;
        rx_data_next  = rx_data;

        unique case (state)
            IDLE: begin
                cs_b_next  = 1'b1;
                sck_next   = 1'b0;
                mosi_next  = 1'b0;
                phase_next = '0;
                if (cs_req) begin
                    cs_b_next  = 1'b0;
                    state_next = SETUP;
                end
            end

            SETUP: begin
                if (phase == HALF_END) begin
                    phase_next    = '0;
                    state_next    = ACTIVE;
                    tx_ready_next = cs_req;
                end else begin
                    phase_next = phase + PH_ONE;
                end
            end

            ACTIVE: begin
                if (accept) begin
                    tx_sh_next   = tx_data[6:0];
                    mosi_next    = tx_data[7];
                    phase_next   = '0;
                    bit_cnt_next = 3'd0;
                    state_next   = SHIFT;
                end else if (!cs_req) begin
                    cs_b_next  = 1'b1;
                    mosi_next  = 1'b0;
                    phase_next = '0;
                    state_next = RELEASE;
                end else begin
                    tx_ready_next = 1'b1;
                end
            end

            SHIFT: begin
                if (phase != HALF_END) begin
                    phase_next = phase + PH_ONE;
                end else begin
                    phase_next = '0;
                    if (!spi_sck) begin
                        // Rising SCK: flash data is sampled here.
                        sck_next   = 1'b1;
                        rx_sh_next = {rx_sh[6:0], spi_miso};
                    end else begin
                        sck_next     = 1'b0;
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // MOSI holds its last bit until the next accept.
                            rx_data_next  = rx_sh;
                            rx_valid_next = 1'b1;
                            state_next    = RX_WAIT;
                        end else begin
                            mosi_next  = tx_sh[6];
                            tx_sh_next = {tx_sh[5:0], 1'b0};
                        end
                    end
                end
            end

            RX_WAIT: begin
                if (rx_ready) begin
                    rx_valid_next = 1'b0;
                    state_next    = ACTIVE;
                    tx_ready_next = cs_req;
                end
            end

            RELEASE: begin
                cs_b_next = 1'b1;
                mosi_next = 1'b0;
                if (phase == REL_END) begin
                    phase_next = '0;
                    state_next = IDLE;
                end else begin
                    phase_next = phase + PH_ONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 7'd0;
            rx_sh    <= 8'd0;
            spi_cs_b <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
            busy     <= 1'b0;
        end else begin
            phase    <= phase_next;
            bit_cnt  <= bit_cnt_next;
            tx_sh    <= tx_sh_next;
            rx_sh    <= rx_sh_next;
            spi_cs_b <= cs_b_next;
            spi_sck  <= sck_next;
            spi_mosi <= mosi_next;
            tx_ready <= tx_ready_next;
            rx_valid <= rx_valid_next;
            rx_data  <= rx_data_next;
            busy     <= busy_next;
        end
    end

endmodule

// File: tb/tb_spi_flash_xfer.sv
// tb_spi_flash_xfer: directed/random bench for spi_flash_xfer at
// CLK_DIV = 2, 3 and 1 against a behavioural SPI flash model.

module tb_spi_flash_xfer;

    localparam int D0 = 2;
    localparam int D1 = 3;
    localparam int D2 = 1;
    localparam int W_RDY  = 0;
    localparam int W_RXV  = 1;
    localparam int W_IDLE = 2;
    localparam int W_CSLO = 3;
    localparam int W_CSHI = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cs_req   [3];
    logic       tx_valid [3];
    logic       rx_ready [3];
    logic [7:0] tx_data  [3];
    logic       tx_ready [3];
    logic       rx_valid [3];
    logic       busy     [3];
    logic       spi_cs_b [3];
    logic       spi_sck  [3];
    logic       spi_mosi [3];
    logic [7:0] rx_data  [3];
    logic       f_miso = 1'b0;

    int cur = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_flash_xfer #(.CLK_DIV(D0)) dut0 (
        .clk(clk), .reset_n(reset_n), .cs_req(cs_req[0]),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
        .rx_valid(rx_valid[0]), .rx_data(rx_data[0]), .rx_ready(rx_ready[0]),
        .busy(busy[0]), .spi_cs_b(spi_cs_b[0]), .spi_sck(spi_sck[0]),
        .spi_mosi(spi_mosi[0]), .spi_miso(f_miso)
    );
    spi_flash_xfer #(.CLK_DIV(D1)) dut1 (
        .clk(clk), .reset_n(reset_n), .cs_req(cs_req[1]),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
        .rx_valid(rx_valid[1]), .rx_data(rx_data[1]), .rx_ready(rx_ready[1]),
        .busy(busy[1]), .spi_cs_b(spi_cs_b[1]), .spi_sck(spi_sck[1]),
        .spi_mosi(spi_mosi[1]), .spi_miso(f_miso)
    );
    spi_flash_xfer #(.CLK_DIV(D2)) dut2 (
        .clk(clk), .reset_n(reset_n), .cs_req(cs_req[2]),
        .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .tx_ready(tx_ready[2]),
        .rx_valid(rx_valid[2]), .rx_data(rx_data[2]), .rx_ready(rx_ready[2]),
        .busy(busy[2]), .spi_cs_b(spi_cs_b[2]), .spi_sck(spi_sck[2]),
        .spi_mosi(spi_mosi[2]), .spi_miso(f_miso)
    );

    // Flash model: attached to whichever instance is under test.
    logic f_sck;
    logic f_cs_b;
    logic f_mosi;
    assign f_sck  = spi_sck[cur];
    assign f_cs_b = spi_cs_b[cur];
    assign f_mosi = spi_mosi[cur];

    logic [7:0] resp_q [$];
    logic [7:0] got_q  [$];
    logic       cs_prev = 1'b1;
    logic       sck_prev = 1'b0;
    logic [7:0] f_cur = 8'd0;
    logic [7:0] f_sh = 8'd0;
    int         ftx = 0;
    int         frx = 0;
    int         f_rises = 0;

    function automatic logic [7:0] pop_resp();
        if (resp_q.size() > 0) return resp_q.pop_front();
        return 8'h00;
    endfunction

    always @(f_sck or f_cs_b) begin
        if (f_cs_b !== cs_prev) begin
            cs_prev = f_cs_b;
            if (f_cs_b === 1'b0) begin
                ftx = 0;
                frx = 0;
                f_cur = pop_resp();
                f_miso = f_cur[7];
            end
        end
        if (f_sck !== sck_prev) begin
            sck_prev = f_sck;
            if (f_cs_b === 1'b0 && f_sck === 1'b1) begin
                f_sh = {f_sh[6:0], f_mosi};
                frx++;
                f_rises++;
                if (frx == 8) begin
                    got_q.push_back(f_sh);
                    frx = 0;
                end
            end else if (f_cs_b === 1'b0) begin
                ftx++;
                if (ftx == 8) begin
                    ftx = 0;
                    f_cur = pop_resp();
                end
                f_miso = f_cur[3'(7 - ftx)];
            end
        end
    end

    // Burst bookkeeping.
    logic [7:0] tx_b [8];
    logic [7:0] rs_b [8];
    logic [7:0] rxd  [8];
    int         acc  [8];
    int         rv   [8];
    int         t_req, t_cs, t_rdy, r0, np;
    bit         cs_rose;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] outs(input int i);
        return {spi_cs_b[i], spi_sck[i], spi_mosi[i], tx_ready[i],
                rx_valid[i], busy[i], rx_data[i]};
    endfunction

    function automatic logic [8:0] got_at(input int j);
        if (j < got_q.size()) return {1'b0, got_q[j]};
        return 9'h100;
    endfunction

    function automatic bit cond(input int i, input int w);
        case (w)
            W_RDY:   return tx_ready[i];
            W_RXV:   return rx_valid[i];
            W_IDLE:  return !busy[i];
            W_CSLO:  return !spi_cs_b[i];
            W_CSHI:  return spi_cs_b[i];
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int i, input int w, input int lim,
                            output bit ok);
        ok = 1'b0;
        for (int n = 0; n < lim; n++) begin
            if (cond(i, w)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Opens a transaction and streams n bytes with rx_ready held high.
    task automatic burst(input int i, input int n);
        int  k;
        int  p;
        bit  pend;
        resp_q.delete();
        got_q.delete();
        for (int j = 0; j < n; j++) resp_q.push_back(rs_b[j]);
        r0 = f_rises;
        cs_rose = 1'b0;
        t_cs = -1;
        t_rdy = -1;
        k = 0;
        p = 0;
        cs_req[i] = 1'b1;
        rx_ready[i] = 1'b1;
        tx_valid[i] = 1'b1;
        tx_data[i] = tx_b[0];
        t_req = cyc;
        for (int m = 0; m < 2000 && p < n; m++) begin
            pend = tx_valid[i] && tx_ready[i];
            if (tx_ready[i] && t_rdy < 0) t_rdy = cyc;
            step();
            if (t_cs < 0 && !spi_cs_b[i]) t_cs = cyc;
            if (t_cs >= 0 && spi_cs_b[i]) cs_rose = 1'b1;
            if (pend) begin
                acc[k] = cyc;
                k++;
                if (k < n) tx_data[i] = tx_b[k];
                else tx_valid[i] = 1'b0;
            end
            if (rx_valid[i]) begin
                rv[p] = cyc;
                rxd[p] = rx_data[i];
                p++;
            end
        end
        tx_valid[i] = 1'b0;
        np = p;
    endtask

    // From the sample where the last rx_valid was seen: let the handshake
    // return to ACTIVE, drop cs_req, and expect CS high on the next edge.
    task automatic close(input int i, input string tag);
        bit ok;
        step();
        cs_req[i] = 1'b0;
        step();
        chk({tag, "_cs_hi_1cyc"}, 32'(spi_cs_b[i]), 32'd1);
        wait_for(i, W_IDLE, 100, ok);
        chk({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    initial begin
        bit         ok;
        int         a;
        int         th;
        int         rvc;
        logic [7:0] b1, b2, r1, r2, d0;
        bit         rdy_seen, sck_seen, unstable;

        for (int i = 0; i < 3; i++) begin
            cs_req[i] = 1'b0;
            tx_valid[i] = 1'b0;
            rx_ready[i] = 1'b0;
            tx_data[i] = 8'd0;
        end
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_outs_%0d", i), 32'(outs(i)), 32'h2000);

        // Single byte, CLK_DIV=2: 0x9F out, 0xA5 back.
        cur = 0;
        tx_b[0] = 8'h9F;
        rs_b[0] = 8'hA5;
        burst(0, 1);
        chk("t1_nbytes", 32'(np), 32'd1);
        chk("t1_cs_lat", 32'(t_cs - t_req), 32'd1);
        chk("t1_rdy_lat", 32'(t_rdy - t_cs), 32'(D0));
        chk("t1_rx_lat", 32'(rv[0] - acc[0]), 32'(16 * D0));
        chk("t1_rx_data", 32'(rxd[0]), 32'hA5);
        chk("t1_mosi", 32'(got_at(0)), 32'h9F);
        chk("t1_sck_pulses", 32'(f_rises - r0), 32'd8);
        close(0, "t1");

        // Four-byte read command burst.
        tx_b[0] = 8'h03;
        tx_b[1] = 8'h00;
        tx_b[2] = 8'h10;
        tx_b[3] = 8'h00;
        for (int j = 0; j < 4; j++) rs_b[j] = 8'($urandom);
        burst(0, 4);
        chk("t2_rx_pulses", 32'(np), 32'd4);
        chk("t2_cs_held", 32'(cs_rose), 32'd0);
        for (int j = 0; j < 3; j++)
            chk($sformatf("t2_pitch_%0d", j), 32'(acc[j+1] - acc[j]),
                32'(16 * D0 + 2));
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t2_rx_%0d", j), 32'(rxd[j]), 32'(rs_b[j]));
            chk($sformatf("t2_tx_%0d", j), 32'(got_at(j)), 32'(tx_b[j]));
        end
        chk("t2_sck_pulses", 32'(f_rises - r0), 32'd32);
        close(0, "t2");

        // Consumer stalls for 50 cycles after the first byte.
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        resp_q.delete();
        got_q.delete();
        resp_q.push_back(r1);
        resp_q.push_back(r2);
        cs_req[0] = 1'b1;
        rx_ready[0] = 1'b0;
        tx_valid[0] = 1'b1;
        tx_data[0] = b1;
        wait_for(0, W_RDY, 20, ok);
        chk("t3_rdy", 32'(ok), 32'd1);
        step();
        tx_data[0] = b2;
        wait_for(0, W_RXV, 16 * D0 + 5, ok);
        chk("t3_rxv1", 32'(ok), 32'd1);
        d0 = rx_data[0];
        chk("t3_rx1", 32'(d0), 32'(r1));
        rdy_seen = 1'b0;
        sck_seen = 1'b0;
        unstable = 1'b0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (tx_ready[0]) rdy_seen = 1'b1;
            if (spi_sck[0]) sck_seen = 1'b1;
            if (rx_data[0] !== d0 || !rx_valid[0]) unstable = 1'b1;
        end
        chk("t3_txr_low", 32'(rdy_seen), 32'd0);
        chk("t3_sck_idle", 32'(sck_seen), 32'd0);
        chk("t3_rx_stable", 32'(unstable), 32'd0);
        rx_ready[0] = 1'b1;
        step();
        chk("t3_resume", {30'd0, tx_ready[0], rx_valid[0]}, 32'd2);
        step();
        a = cyc;
        tx_valid[0] = 1'b0;
        wait_for(0, W_RXV, 16 * D0 + 5, ok);
        chk("t3_rx2_lat", 32'(cyc - a), 32'(16 * D0));
        chk("t3_rx2", 32'(rx_data[0]), 32'(r2));
        close(0, "t3");
        chk("t3_tx1", 32'(got_at(0)), 32'(b1));
        chk("t3_tx2", 32'(got_at(1)), 32'(b2));

        // cs_req dropped mid-byte, then re-raised as CS goes high.
        b1 = 8'($urandom);
        r1 = 8'($urandom);
        resp_q.delete();
        got_q.delete();
        resp_q.push_back(r1);
        cs_req[0] = 1'b1;
        rx_ready[0] = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0] = b1;
        wait_for(0, W_RDY, 20, ok);
        step();
        a = cyc;
        tx_valid[0] = 1'b0;
        repeat (10) step();
        cs_req[0] = 1'b0;
        wait_for(0, W_RXV, 60, ok);
        chk("t4_rxv", 32'(ok), 32'd1);
        chk("t4_lat", 32'(cyc - a), 32'(16 * D0));
        chk("t4_rx", 32'(rx_data[0]), 32'(r1));
        chk("t4_cs_low", 32'(spi_cs_b[0]), 32'd0);
        rvc = cyc;
        wait_for(0, W_CSHI, 20, ok);
        chk("t4_release", 32'(cyc - rvc), 32'd2);
        th = cyc;
        cs_req[0] = 1'b1;
        wait_for(0, W_CSLO, 30, ok);
        chk("t4_reraise", 32'(cyc - th), 32'(2 * D0 + 1));
        chk("t4_tx", 32'(got_at(0)), 32'(b1));
        cs_req[0] = 1'b0;
        wait_for(0, W_IDLE, 100, ok);
        chk("t4_idle", 32'(ok), 32'd1);

        // Reset pulse mid-byte at CLK_DIV=3, then a clean 0xFF transfer.
        cur = 1;
        resp_q.delete();
        got_q.delete();
        resp_q.push_back(8'($urandom));
        cs_req[1] = 1'b1;
        rx_ready[1] = 1'b1;
        tx_valid[1] = 1'b1;
        tx_data[1] = 8'($urandom);
        wait_for(1, W_RDY, 20, ok);
        chk("t5_rdy", 32'(ok), 32'd1);
        step();
        tx_valid[1] = 1'b0;
        repeat (20) step();
        chk("t5_mid_busy", 32'(busy[1]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_rst", 32'(outs(1)), 32'h2000);
        cs_req[1] = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("t5_after_rst", 32'(outs(1)), 32'h2000);
        tx_b[0] = 8'hFF;
        rs_b[0] = 8'($urandom);
        burst(1, 1);
        chk("t5_nbytes", 32'(np), 32'd1);
        chk("t5_rx_lat", 32'(rv[0] - acc[0]), 32'(16 * D1));
        chk("t5_rx", 32'(rxd[0]), 32'(rs_b[0]));
        chk("t5_tx", 32'(got_at(0)), 32'hFF);
        chk("t5_sck_pulses", 32'(f_rises - r0), 32'd8);
        close(1, "t5");

        // CLK_DIV=1: 16-cycle bytes.
        cur = 2;
        for (int j = 0; j < 2; j++) begin
            tx_b[j] = 8'($urandom);
            rs_b[j] = 8'($urandom);
        end
        burst(2, 2);
        chk("t6_nbytes", 32'(np), 32'd2);
        chk("t6_rdy_lat", 32'(t_rdy - t_cs), 32'(D2));
        chk("t6_rx_lat", 32'(rv[0] - acc[0]), 32'(16 * D2));
        chk("t6_pitch", 32'(acc[1] - acc[0]), 32'(16 * D2 + 2));
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("t6_rx_%0d", j), 32'(rxd[j]), 32'(rs_b[j]));
            chk($sformatf("t6_tx_%0d", j), 32'(got_at(j)), 32'(tx_b[j]));
        end
        chk("t6_sck_pulses", 32'(f_rises - r0), 32'd16);
        close(2, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
